imem_boot_loader: RTL and testbench

- Boot-time controller that owns the write side of the 1024x32 instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into consecutive instruction-memory locations starting at word 0.
- Holds the core in reset until the programmed word count has been written, then releases it. The fetch read address passes through unchanged.

---
 rtl/imem_boot_loader.sv | 149 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to
// instruction memory from word 0, holding the core in reset until the requested count is loaded.
module imem_boot_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_Start,
    input  logic [ADDR_W:0]   i_Length,
    input  logic              i_ByteValid,
    input  logic [7:0]        i_Byte,
    output logic              o_ByteReady,
    output logic              o_MemWe,
    output logic [ADDR_W-1:0] o_MemWaddr,
    output logic [31:0]       o_MemWdata,
    input  logic [ADDR_W-1:0] i_FetchAddr,
    output logic [ADDR_W-1:0] o_MemRaddr,
    output logic              o_CoreHold,
    output logic              o_Done,
    output logic              o_Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t              state_q,     state_d;
    logic [1:0]          byte_cnt_q,  byte_cnt_d;
    logic [ADDR_W:0]     word_cnt_q,  word_cnt_d;
    logic [ADDR_W:0]     len_q,       len_d;
    logic [31:0]         word_buf_q,  word_buf_d;
    logic                byte_rdy_q,  byte_rdy_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                core_hold_q, core_hold_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;

    logic                len_ok;
    logic [ADDR_W:0]     word_cnt_inc;

    // Full ADDR_W+1 bit compare so a DEPTH-word load terminates instead of wrapping.
    assign len_ok       = (i_Length != '0) && (i_Length <= DEPTH_L);
    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        word_buf_d  = word_buf_q;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_Start) begin
                    if (len_ok) begin
                        state_d    = S_RECV;
                        len_d      = i_Length;
                        byte_cnt_d = '0;
                        word_cnt_d = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_RECV: begin
                if (i_ByteValid && byte_rdy_q) begin
                    word_buf_d[{byte_cnt_q, 3'b000} +: 8] = i_Byte;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (word_cnt_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_inc;
                    state_d    = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        byte_rdy_d  = (state_d == S_RECV);
        mem_we_d    = (state_d == S_WRITE);
        core_hold_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERR);
        if (state_d == S_WRITE) begin
            mem_waddr_d = word_cnt_d[ADDR_W-1:0];
            mem_wdata_d = word_buf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            len_q       <= '0;
            word_buf_q  <= '0;
            byte_rdy_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            word_buf_q  <= word_buf_d;
            byte_rdy_q  <= byte_rdy_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign o_ByteReady = byte_rdy_q;
    assign o_MemWe     = mem_we_q;
    assign o_MemWaddr  = mem_waddr_q;
    assign o_MemWdata  = mem_wdata_q;
    assign o_CoreHold  = core_hold_q;
    assign o_Done      = done_q;
    assign o_Error     = error_q;
    assign o_MemRaddr  = i_FetchAddr;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: loads, error lengths, full-depth load, reset mid-load.
module tb_imem_boot_loader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_Start = 1'b0;
    logic [10:0] i_Length = '0;
    logic        i_ByteValid = 1'b0;
    logic [7:0]  i_Byte = '0;
    logic        o_ByteReady;
    logic        o_MemWe;
    logic [9:0]  o_MemWaddr;
    logic [31:0] o_MemWdata;
    logic [9:0]  i_FetchAddr = '0;
    logic [9:0]  o_MemRaddr;
    logic        o_CoreHold;
    logic        o_Done;
    logic        o_Error;

    imem_boot_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_Start     (i_Start),
        .i_Length    (i_Length),
        .i_ByteValid (i_ByteValid),
        .i_Byte      (i_Byte),
        .o_ByteReady (o_ByteReady),
        .o_MemWe     (o_MemWe),
        .o_MemWaddr  (o_MemWaddr),
        .o_MemWdata  (o_MemWdata),
        .i_FetchAddr (i_FetchAddr),
        .o_MemRaddr  (o_MemRaddr),
        .o_CoreHold  (o_CoreHold),
        .o_Done      (o_Done),
        .o_Error     (o_Error)
    );

    always #5 i_clk = ~i_clk;

    // Captured instruction memory and write statistics.
    logic [31:0] mem [1024];
    int          we_count = 0;
    int          a0_count = 0;
    logic [9:0]  last_waddr = '0;

    always @(posedge i_clk) begin
        if (o_MemWe) begin
            mem[o_MemWaddr] <= o_MemWdata;
            we_count        <= we_count + 1;
            last_waddr      <= o_MemWaddr;
            if (o_MemWaddr == 10'd0) a0_count <= a0_count + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    logic [7:0] byte_q [$];
    int         we_cyc [4];
    int         nwe;
    bit         rdy_in_write;
    bit         hold_at_end;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Start a load in cycle 0, stream byte_q, and return the cycle where o_Done or o_Error appears.
    task automatic run_load(input logic [10:0] len, input bit toggle, input int restart_cyc,
                            input int maxc, output int end_cyc);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        nwe = 0;
        rdy_in_write = 1'b0;
        end_cyc = -1;
        i_Start = 1'b1;
        i_Length = len;
        i_ByteValid = 1'b0;
        tick();
        i_Start = 1'b0;
        cyc = 1;
        while (cyc < maxc) begin
            if (o_MemWe) begin
                if (nwe < 4) we_cyc[nwe] = cyc;
                nwe++;
                if (o_ByteReady) rdy_in_write = 1'b1;
            end
            if (o_Done || o_Error) begin
                end_cyc = cyc;
                hold_at_end = o_CoreHold;
                break;
            end
            i_Start = (cyc == restart_cyc);
            if (cyc == restart_cyc) i_Length = 11'd1;
            i_ByteValid = (idx < byte_q.size()) && (!toggle || cyc[0]);
            i_Byte = (idx < byte_q.size()) ? byte_q[idx] : 8'h00;
            acc = i_ByteValid && o_ByteReady;
            tick();
            if (acc) idx++;
            cyc++;
        end
        i_Start = 1'b0;
        i_ByteValid = 1'b0;
        if (end_cyc < 0) chk("load_timeout", 32'(cyc), 32'(maxc + 1));
    endtask

    initial begin
        int end_cyc;
        int base_we;
        int base_a0;
        int acc_idx;

        tick();
        tick();
        chk("rst_hold",  {31'd0, o_CoreHold},  32'd1);
        chk("rst_ready", {31'd0, o_ByteReady}, 32'd0);
        chk("rst_we",    {31'd0, o_MemWe},     32'd0);
        chk("rst_done",  {31'd0, o_Done},      32'd0);
        chk("rst_error", {31'd0, o_Error},     32'd0);
        chk("rst_waddr", {22'd0, o_MemWaddr},  32'd0);
        chk("rst_wdata", o_MemWdata,           32'd0);
        i_rst = 1'b0;
        tick();

        // Two words, valid every cycle
        byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h01};
        base_we = we_count;
        run_load(11'd2, 1'b0, -1, 40, end_cyc);
        chk("t1_we_cycle0", 32'(we_cyc[0]), 32'd5);
        chk("t1_we_cycle1", 32'(we_cyc[1]), 32'd10);
        chk("t1_done_cycle", 32'(end_cyc), 32'd11);
        chk("t1_hold_done", {31'd0, hold_at_end}, 32'd0);
        chk("t1_done", {31'd0, o_Done}, 32'd1);
        chk("t1_mem0", mem[0], 32'h0000_0013);
        chk("t1_mem1", mem[1], 32'h0100_0513);
        chk("t1_we_count", 32'(we_count - base_we), 32'd2);
        chk("t1_rdy_in_write", {31'd0, rdy_in_write}, 32'd0);

        // Valid toggling 1/0
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        base_we = we_count;
        run_load(11'd2, 1'b1, -1, 60, end_cyc);
        chk("t2_mem0", mem[0], 32'hDDCC_BBAA);
        chk("t2_mem1", mem[1], 32'h4433_2211);
        chk("t2_we_count", 32'(we_count - base_we), 32'd2);
        chk("t2_rdy_in_write", {31'd0, rdy_in_write}, 32'd0);
        chk("t2_done", {31'd0, o_Done}, 32'd1);

        // Start pulse during RECV must not relatch the length
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        base_we = we_count;
        run_load(11'd2, 1'b0, 2, 40, end_cyc);
        chk("t3_done_cycle", 32'(end_cyc), 32'd11);
        chk("t3_we_count", 32'(we_count - base_we), 32'd2);
        chk("t3_mem1", mem[1], 32'h0807_0605);

        // Illegal lengths
        byte_q = {};
        run_load(11'd0, 1'b0, -1, 10, end_cyc);
        chk("t4_len0_cycle", 32'(end_cyc), 32'd1);
        chk("t4_len0_error", {31'd0, o_Error}, 32'd1);
        chk("t4_len0_hold",  {31'd0, o_CoreHold}, 32'd1);
        chk("t4_len0_done",  {31'd0, o_Done}, 32'd0);
        run_load(11'd1025, 1'b0, -1, 10, end_cyc);
        chk("t4_len1025_error", {31'd0, o_Error}, 32'd1);
        chk("t4_len1025_hold",  {31'd0, o_CoreHold}, 32'd1);
        byte_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(11'd1, 1'b0, -1, 20, end_cyc);
        chk("t4_recover_cycle", 32'(end_cyc), 32'd6);
        chk("t4_recover_error", {31'd0, o_Error}, 32'd0);
        chk("t4_recover_done",  {31'd0, o_Done}, 32'd1);
        chk("t4_recover_mem0",  mem[0], 32'hDEAD_BEEF);

        // Full-depth load, word i = 0xA5000000 | i
        byte_q = {};
        for (int i = 0; i < 1024; i++) begin
            byte_q.push_back(8'(i));
            byte_q.push_back(8'(i >> 8));
            byte_q.push_back(8'h00);
            byte_q.push_back(8'hA5);
        end
        base_we = we_count;
        base_a0 = a0_count;
        run_load(11'd1024, 1'b0, -1, 6000, end_cyc);
        chk("t5_done_cycle", 32'(end_cyc), 32'd5121);
        chk("t5_we_count", 32'(we_count - base_we), 32'd1024);
        chk("t5_addr0_writes", 32'(a0_count - base_a0), 32'd1);
        chk("t5_last_waddr", {22'd0, last_waddr}, 32'd1023);
        chk("t5_mem0",    mem[0],    32'hA500_0000);
        chk("t5_mem513",  mem[513],  32'hA500_0201);
        chk("t5_mem1023", mem[1023], 32'hA500_03FF);
        chk("t5_done", {31'd0, o_Done}, 32'd1);

        // Fetch address passthrough while in DONE
        for (int a = 0; a < 16; a++) begin
            i_FetchAddr = 10'(a * 67 + 3);
            #1;
            chk("fetch_passthrough", {22'd0, o_MemRaddr}, 32'(a * 67 + 3));
        end
        chk("fetch_still_done", {31'd0, o_Done}, 32'd1);

        // Reset after two bytes of the third word
        base_we = we_count;
        i_Start = 1'b1;
        i_Length = 11'd4;
        tick();
        i_Start = 1'b0;
        acc_idx = 0;
        for (int c = 1; c < 13; c++) begin
            i_ByteValid = 1'b1;
            i_Byte = 8'(8'h60 + acc_idx);
            if (o_ByteReady) acc_idx++;
            tick();
        end
        chk("t6_bytes_before_rst", 32'(acc_idx), 32'd10);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t6_hold",  {31'd0, o_CoreHold},  32'd1);
        chk("t6_ready", {31'd0, o_ByteReady}, 32'd0);
        chk("t6_we",    {31'd0, o_MemWe},     32'd0);
        for (int c = 0; c < 10; c++) tick();
        i_ByteValid = 1'b0;
        chk("t6_no_more_writes", 32'(we_count - base_we), 32'd2);
        chk("t6_idle_ready", {31'd0, o_ByteReady}, 32'd0);
        byte_q = '{8'h44, 8'h33, 8'h22, 8'h11};
        run_load(11'd1, 1'b0, -1, 20, end_cyc);
        chk("t6_restart_cycle", 32'(end_cyc), 32'd6);
        chk("t6_restart_mem0", mem[0], 32'h1122_3344);
        chk("t6_restart_waddr", {22'd0, last_waddr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
